// File: rtl/alu_ctrl_dmem_if.sv
// Bus bundle for the decode/execute/memory slice: operands in, ALU/write-back
// results and decoded control out.
interface alu_ctrl_dmem_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      instr;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] result;
    logic             eq;
    logic             reg_write;
    logic             branch;
    logic [1:0]       jump;
    logic [2:0]       imm_src;
    logic             wd3_src;
    logic             result_src;
    logic             wdme;
    logic             alu_src;
    logic             floating;
    logic             exit;
    logic             halted;

    modport master (
        output instr, rd1, rd2, imm,
        input  alu_result, result, eq, reg_write, branch, jump, imm_src,
               wd3_src, result_src, wdme, alu_src, floating, exit, halted
    );

    modport slave (
        input  instr, rd1, rd2, imm,
        output alu_result, result, eq, reg_write, branch, jump, imm_src,
               wd3_src, result_src, wdme, alu_src, floating, exit, halted
    );
endinterface

// File: rtl/alu_ctrl_dmem.sv
// Single-cycle decode / 32-bit ALU / word data memory slice with sticky halt.
// Optional feature macro: ALU_MUL_EN (alu_ctrl 1011 becomes MUL).
module alu_ctrl_dmem #(
    parameter int WIDTH      = 32,
    parameter int DMEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            rst,
    alu_ctrl_dmem_if.slave  bus
);
    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RALU  = 6'b000000;
    localparam logic [5:0] OP_IALU  = 6'b000001;
    localparam logic [5:0] OP_LOAD  = 6'b000010;
    localparam logic [5:0] OP_STORE = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_CALL  = 6'b000101;
    localparam logic [5:0] OP_JALR  = 6'b000110;
    localparam logic [5:0] OP_FPR   = 6'b000111;
    localparam logic [5:0] OP_EXIT  = 6'b111111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_MUL   = 4'b1011;

    logic [5:0] opcode;
    logic [3:0] funct4;
    logic       unusedInstrBits;

    assign opcode = bus.instr[31:26];
    assign funct4 = bus.instr[13:10];
    // Register specifiers are consumed by the register file, not by this slice.
    assign unusedInstrBits = ^{bus.instr[25:14], bus.instr[9:0]};

    logic [3:0] aluCtrl;
    logic       regWrite, branch, wd3Src, resultSrc, wdme, aluSrc, floating, exitC;
    logic [1:0] jump;
    logic [2:0] immSrc;

    always_comb begin
        // NOTE: every decoded signal gets a default before the case so no path leaves one unassigned (no latches).
        aluCtrl   = ALU_ADD;
        regWrite  = 1'b0;
        branch    = 1'b0;
        jump      = 2'b00;
        immSrc    = 3'b000;
        wd3Src    = 1'b0;
        resultSrc = 1'b0;
        wdme      = 1'b0;
        aluSrc    = 1'b0;
        floating  = 1'b0;
        exitC     = 1'b0;
        case (opcode)
            OP_RALU:  begin aluCtrl = funct4; regWrite = 1'b1; end
            OP_IALU:  begin aluCtrl = funct4; aluSrc = 1'b1; regWrite = 1'b1; end
            OP_LOAD:  begin aluSrc = 1'b1; regWrite = 1'b1; resultSrc = 1'b1; end
            OP_STORE: begin aluSrc = 1'b1; wdme = 1'b1; immSrc = 3'b001; end
            OP_BEQ:   begin aluCtrl = ALU_SUB; branch = 1'b1; immSrc = 3'b010; end
            OP_CALL:  begin jump = 2'b10; regWrite = 1'b1; wd3Src = 1'b1; immSrc = 3'b011; end
            OP_JALR:  begin jump = 2'b11; aluSrc = 1'b1; end
            OP_FPR:   begin aluCtrl = funct4; floating = 1'b1; regWrite = 1'b1; end
            OP_EXIT:  exitC = 1'b1;
            default:  ;
        endcase
    end

    logic [WIDTH-1:0] op1, op2, aluOut;
    logic [4:0]       shamt;

    assign op1   = bus.rd1;
    assign op2   = aluSrc ? bus.imm : bus.rd2;
    assign shamt = op2[4:0];

    always_comb begin
        aluOut = '0;
        case (aluCtrl)
            ALU_ADD:   aluOut = op1 + op2;
            ALU_SUB:   aluOut = op1 - op2;
            ALU_AND:   aluOut = op1 & op2;
            ALU_OR:    aluOut = op1 | op2;
            ALU_XOR:   aluOut = op1 ^ op2;
            ALU_SLL:   aluOut = op1 << shamt;
            ALU_SRL:   aluOut = op1 >> shamt;
            ALU_SRA:   aluOut = $signed(op1) >>> shamt;
            ALU_SLT:   aluOut = WIDTH'($signed(op1) < $signed(op2));
            ALU_SLTU:  aluOut = WIDTH'(op1 < op2);
            ALU_PASSB: aluOut = op2;
`ifdef ALU_MUL_EN
            ALU_MUL:   aluOut = op1 * op2;
`else
            ALU_MUL:   aluOut = '0;
`endif
            default:   aluOut = '0;
        endcase
    end

    logic [WIDTH-1:0] mem [DMEM_WORDS];
    logic [AW-1:0]    wordIdx;
    logic             haltedQ;

    // Upper address bits and the byte offset are dropped: word access that wraps.
    assign wordIdx = aluOut[AW+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            haltedQ <= 1'b0;
            // NOTE: the whole memory is cleared by reset, so it must be built from flops, not a RAM macro.
            for (int i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
        end else begin
            // NOTE: non-blocking writes here keep a same-cycle load returning the pre-edge word.
            if (wdme && !haltedQ) mem[wordIdx] <= bus.rd2;
            if (exitC) haltedQ <= 1'b1;
        end
    end

    assign bus.alu_result = aluOut;
    assign bus.result     = resultSrc ? mem[wordIdx] : aluOut;
    assign bus.eq         = (op1 == op2);
    assign bus.reg_write  = regWrite;
    assign bus.branch     = branch;
    assign bus.jump       = jump;
    assign bus.imm_src    = immSrc;
    assign bus.wd3_src    = wd3Src;
    assign bus.result_src = resultSrc;
    assign bus.wdme       = wdme;
    assign bus.alu_src    = aluSrc;
    assign bus.floating   = floating;
    assign bus.exit       = exitC;
    assign bus.halted     = haltedQ;
endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Scoreboard bench for alu_ctrl_dmem: a driver issues one instruction per cycle
// and queues the reference-model answer; a monitor pops and compares on negedge.
`timescale 1ns/1ps
module tb_alu_ctrl_dmem;
    localparam int WIDTH      = 32;
    localparam int DMEM_WORDS = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_dmem_if #(.WIDTH(WIDTH)) bus ();

    alu_ctrl_dmem #(.WIDTH(WIDTH), .DMEM_WORDS(DMEM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       regWrite;
        logic       branch;
        logic [1:0] jump;
        logic [2:0] immSrc;
        logic       wd3Src;
        logic       resultSrc;
        logic       wdme;
        logic       aluSrc;
        logic       floating;
        logic       exitC;
        logic [3:0] aluOp;
    } ctlT;

    typedef struct {
        string       tag;
        logic [31:0] aluResult;
        logic [31:0] result;
        logic        eq;
        logic [13:0] ctl;
        logic        halted;
    } expT;

    expT         expQ[$];
    logic [31:0] modelMem [DMEM_WORDS];
    bit          modelHalted;
    int          nChecks = 0;
    int          nFails  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic ctlT refDecode(logic [5:0] op, logic [3:0] f4);
        ctlT c = '0;
        case (op)
            6'd0:  begin c.aluOp = f4; c.regWrite = 1'b1; end
            6'd1:  begin c.aluOp = f4; c.aluSrc = 1'b1; c.regWrite = 1'b1; end
            6'd2:  begin c.aluSrc = 1'b1; c.regWrite = 1'b1; c.resultSrc = 1'b1; end
            6'd3:  begin c.aluSrc = 1'b1; c.wdme = 1'b1; c.immSrc = 3'd1; end
            6'd4:  begin c.aluOp = 4'd1; c.branch = 1'b1; c.immSrc = 3'd2; end
            6'd5:  begin c.jump = 2'd2; c.regWrite = 1'b1; c.wd3Src = 1'b1; c.immSrc = 3'd3; end
            6'd6:  begin c.jump = 2'd3; c.aluSrc = 1'b1; end
            6'd7:  begin c.aluOp = f4; c.floating = 1'b1; c.regWrite = 1'b1; end
            6'd63: c.exitC = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] refAlu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << s;
            4'd6:  return a >> s;
            4'd7:  return (a >> s) | ({32{a[31]}} & ~(32'hFFFF_FFFF >> s));
            4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
`ifdef ALU_MUL_EN
            4'd11: return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(string tag, logic rstVal, logic [5:0] op, logic [3:0] f4,
                         logic [31:0] a, logic [31:0] b, logic [31:0] im);
        logic [31:0] ins, opB, alu;
        ctlT         c;
        expT         e;
        int          idx;
        @(posedge clk);
        #1;
        ins        = $urandom;
        ins[31:26] = op;
        ins[13:10] = f4;
        rst        = rstVal;
        bus.instr  = ins;
        bus.rd1    = a;
        bus.rd2    = b;
        bus.imm    = im;
        if (!rstVal) begin
            for (int i = 0; i < DMEM_WORDS; i++) modelMem[i] = '0;
            modelHalted = 1'b0;
        end
        c   = refDecode(op, f4);
        opB = c.aluSrc ? im : b;
        alu = refAlu(c.aluOp, a, opB);
        idx = int'((alu / 4) % DMEM_WORDS);
        e.tag       = tag;
        e.aluResult = alu;
        e.result    = c.resultSrc ? modelMem[idx] : alu;
        e.eq        = (a == opB);
        e.ctl       = {c.regWrite, c.branch, c.jump, c.immSrc, c.wd3Src, c.resultSrc,
                       c.wdme, c.aluSrc, c.floating, c.exitC};
        e.halted    = modelHalted;
        expQ.push_back(e);
        if (rstVal) begin
            if (c.wdme && !modelHalted) modelMem[idx] = b;
            if (c.exitC) modelHalted = 1'b1;
        end
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check({e.tag, "/alu_result"}, bus.alu_result, e.aluResult);
                check({e.tag, "/result"}, bus.result, e.result);
                check({e.tag, "/eq"}, 32'(bus.eq), 32'(e.eq));
                check({e.tag, "/ctl"},
                      32'({bus.reg_write, bus.branch, bus.jump, bus.imm_src, bus.wd3_src,
                           bus.result_src, bus.wdme, bus.alu_src, bus.floating, bus.exit}),
                      32'(e.ctl));
                check({e.tag, "/halted"}, 32'(bus.halted), 32'(e.halted));
            end
        end
    end

    initial begin : driver
        logic [5:0] op;
        logic       r;
        int         sel;
        logic [31:0] a;
        issue("rst_load_a", 1'b0, 6'd2, 4'd0, 32'h0000_0040, 32'h1, 32'h4);
        issue("rst_load_b", 1'b0, 6'd2, 4'd0, 32'h0000_0108, 32'h2, 32'h0);
        issue("sub", 1'b1, 6'd0, 4'd1, 32'd5, 32'd7, $urandom);
        issue("beq", 1'b1, 6'd4, $urandom, 32'h1234, 32'h1234, $urandom);
        issue("store", 1'b1, 6'd3, 4'd0, 32'h100, 32'hDEAD_BEEF, 32'd8);
        issue("load_st", 1'b1, 6'd2, 4'd0, 32'h100, 32'h0, 32'd8);
        issue("load_wrap", 1'b1, 6'd2, 4'd0, 32'h108 + 4 * DMEM_WORDS, 32'h0, 32'd0);
        issue("sra", 1'b1, 6'd1, 4'd7, 32'h8000_0000, 32'h0, 32'd4);
        issue("slt", 1'b1, 6'd0, 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue("sltu", 1'b1, 6'd0, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue("op11", 1'b1, 6'd0, 4'd11, 32'd6, 32'd7, 32'd0);
        issue("nop2a", 1'b1, 6'h2A, $urandom, $urandom, $urandom, $urandom);
        issue("call", 1'b1, 6'd5, $urandom, $urandom, $urandom, $urandom);
        issue("jalr", 1'b1, 6'd6, $urandom, 32'h400, $urandom, 32'h10);
        issue("fpr", 1'b1, 6'd7, 4'd10, $urandom, 32'h55AA, $urandom);
        issue("exit", 1'b1, 6'd63, 4'd0, 32'h0, 32'h0, 32'h0);
        issue("halt_store", 1'b1, 6'd3, 4'd0, 32'h0, 32'h55, 32'h0);
        issue("halt_load", 1'b1, 6'd2, 4'd0, 32'h0, 32'h0, 32'h0);
        issue("midrst", 1'b0, 6'd2, 4'd0, 32'h100, 32'h0, 32'd8);
        issue("post_rst", 1'b1, 6'd2, 4'd0, 32'h100, 32'h0, 32'd8);

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 19);
            r   = 1'b1;
            if (sel <= 7)       op = 6'(sel);
            else if (sel <= 10) op = 6'd3;
            else if (sel <= 13) op = 6'd2;
            else if (sel == 14) op = 6'd63;
            else if (sel == 15) begin op = 6'd2; r = 1'b0; end
            else                op = 6'($urandom_range(8, 62));
            a = $urandom;
            issue($sformatf("rnd%0d", n), r, op, 4'($urandom_range(0, 15)), a,
                  ($urandom_range(0, 3) == 0) ? a : $urandom,
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom);
        end

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            nFails++;
            $display("FAIL drain: %0d expected responses never compared", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
